// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_wr_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    // Next requester index in rotating order, wrapping n-1 -> 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational rotating-priority picker starting at ptr
module rr_pick #(
    parameter int N    = 4,
    parameter int IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt_onehot,
    output logic [IdxW-1:0] gnt_idx,
    output logic            any
);

    int              cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        any      = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IdxW'(cand);
            if (!any && req[cand_idx]) begin
                any     = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    always_comb begin
        gnt_onehot = '0;
        for (int i = 0; i < N; i++) begin
            gnt_onehot[i] = any && (gnt_idx == IdxW'(i));
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - burst-locked round-robin arbiter for one FIFO write port
// Optional output register on wvalid_o/wdata_o: define FIFO_WR_ARB_OUT_REG_EN.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int Width    = 16,
    parameter int MaxBurst = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic [N-1:0]         req_valid_i,
    input  logic [N-1:0]         req_last_i,
    input  logic [N*Width-1:0]   req_data_i,
    output logic [N-1:0]         req_ready_o,
    output logic                 wvalid_o,
    input  logic                 wready_i,
    output logic [Width-1:0]     wdata_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 busy_o
);

    localparam int IdxW = $clog2(N);
    localparam int CntW = $clog2(MaxBurst + 1);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IdxW-1:0] gnt_q, gnt_d;

    logic [N-1:0]     pick_onehot;
    logic [IdxW-1:0]  pick_idx;
    logic             pick_any;
    logic [N-1:0]     lock_onehot;
    logic [N-1:0]     sel_onehot;
    logic [IdxW-1:0]  sel_idx;
    logic             pres_valid;
    logic             pres_last;
    logic [Width-1:0] pres_data;
    logic             up_ready;
    logic             accept;
    logic [CntW-1:0]  cnt_inc;

    rr_pick #(
        .N    (N),
        .IdxW (IdxW)
    ) u_pick (
        .req        (req_valid_i),
        .ptr        (rr_ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        lock_onehot = '0;
        for (int i = 0; i < N; i++) begin
            lock_onehot[i] = (gnt_q == IdxW'(i));
        end
    end

    // In BURST the locked requester is the only candidate, even while it idles.
    always_comb begin
        if (state_q == ARB_IDLE) begin
            sel_idx    = pick_idx;
            sel_onehot = pick_onehot;
            pres_valid = pick_any;
        end else begin
            sel_idx    = gnt_q;
            sel_onehot = lock_onehot;
            pres_valid = req_valid_i[gnt_q];
        end
        pres_last = req_last_i[sel_idx];
        pres_data = pres_valid ? req_data_i[sel_idx*Width +: Width] : '0;
    end

`ifdef FIFO_WR_ARB_OUT_REG_EN
    logic             out_valid_q;
    logic [Width-1:0] out_data_q;

    assign up_ready = ~out_valid_q | wready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (clr_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (up_ready) begin
            out_valid_q <= pres_valid;
            out_data_q  <= pres_data;
        end
    end

    assign wvalid_o = out_valid_q;
    assign wdata_o  = out_data_q;
`else
    assign up_ready = wready_i;
    assign wvalid_o = rst_ni & pres_valid;
    assign wdata_o  = rst_ni ? pres_data : '0;
`endif

    assign accept  = pres_valid & up_ready;
    assign cnt_inc = beat_cnt_q + CntW'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        gnt_d      = gnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_d = pick_idx;
                end
                if (accept) begin
                    if (!pres_last && (MaxBurst > 1)) begin
                        state_d    = ARB_BURST;
                        beat_cnt_d = CntW'(1);
                    end else begin
                        rr_ptr_d = IdxW'(rr_next(32'(pick_idx), N));
                    end
                end
            end
            ARB_BURST: begin
                if (accept) begin
                    if (pres_last || (cnt_inc == CntW'(MaxBurst))) begin
                        state_d    = ARB_IDLE;
                        rr_ptr_d   = IdxW'(rr_next(32'(gnt_q), N));
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        // A beat accepted in the clear cycle has already transferred; only the arbitration state resets.
        if (clr_i) begin
            state_d    = ARB_IDLE;
            rr_ptr_d   = '0;
            beat_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_q      <= gnt_d;
        end
    end

    assign req_ready_o = (rst_ni && pres_valid && up_ready) ? sel_onehot : '0;
    assign gnt_idx_o   = !rst_ni ? '0 : ((state_q == ARB_IDLE && pick_any) ? pick_idx : gnt_q);
    assign busy_o      = (state_q == ARB_BURST);

endmodule
